// File: rtl/spi_pkg.sv
// Shared types, constants and helpers for the SPI slave.
// Pure declarations: no logic, no latency, no backpressure.
// Word-length encoding is common to the master and the slave.
package spi_pkg;

    typedef enum logic {
        IDLE,
        ACTIVE
    } t_spi_slv_st;

    localparam logic [1:0] SPI_WD_LEN_8  = 2'b00;
    localparam logic [1:0] SPI_WD_LEN_16 = 2'b01;
    localparam logic [1:0] SPI_WD_LEN_24 = 2'b10;
    localparam logic [1:0] SPI_WD_LEN_32 = 2'b11;

    typedef struct packed {
        logic       cpol;
        logic       cpha;
        logic [1:0] wd_len;
    } t_spi_slv_cfg;

    function automatic logic [5:0] spi_wd_bits(input logic [1:0] len);
        return {1'b0, len, 3'b000} + 6'd8;
    endfunction

endpackage

// File: rtl/spi_slv_sync.sv
// Pin synchroniser for csn/sclk/mosi plus sclk leading/trailing and csn edge pulses.
// Latency: SYNC_STG clk cycles from pin to csn_s/mosi_s; edge pulses are combinational on top.
// Backpressure: none, free-running.
module spi_slv_sync #(
    parameter int SYNC_STG = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic spi_csn,
    input  logic spi_clk,
    input  logic spi_mosi,
    input  logic cpol,
    output logic csn_s,
    output logic mosi_s,
    output logic lead_p,
    output logic trail_p,
    output logic csn_fall_p,
    output logic csn_rise_p
);

    logic [SYNC_STG-1:0] csn_sync_q, csn_sync_d;
    logic [SYNC_STG-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STG-1:0] mosi_sync_q, mosi_sync_d;
    logic                sclk_prev_q, sclk_prev_d;
    logic                csn_prev_q, csn_prev_d;
    logic                sclk_s;

    always_comb begin
        csn_sync_d  = {csn_sync_q[SYNC_STG-2:0], spi_csn};
        sclk_sync_d = {sclk_sync_q[SYNC_STG-2:0], spi_clk};
        mosi_sync_d = {mosi_sync_q[SYNC_STG-2:0], spi_mosi};
        sclk_prev_d = sclk_s;
        csn_prev_d  = csn_s;
    end

    // Chains keep tracking the pins during reset so a frame already in
    // progress when reset lifts is not mistaken for a new csn fall.
    always_ff @(posedge clk) begin
        csn_sync_q  <= csn_sync_d;
        sclk_sync_q <= sclk_sync_d;
        mosi_sync_q <= mosi_sync_d;
        sclk_prev_q <= sclk_prev_d;
    end

    // csn_prev resets low: a fall only counts after csn has been seen high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csn_prev_q <= 1'b0;
        end else begin
            csn_prev_q <= csn_prev_d;
        end
    end

    assign csn_s      = csn_sync_q[SYNC_STG-1];
    assign sclk_s     = sclk_sync_q[SYNC_STG-1];
    assign mosi_s     = mosi_sync_q[SYNC_STG-1];
    assign lead_p     = (sclk_s != cpol) && (sclk_prev_q == cpol);
    assign trail_p    = (sclk_s == cpol) && (sclk_prev_q != cpol);
    assign csn_fall_p = !csn_s && csn_prev_q;
    assign csn_rise_p = csn_s && !csn_prev_q;

endmodule

// File: rtl/spi_slv.sv
// SPI slave, all CPOL/CPHA modes, 8/16/24/32-bit MSB-first words; SPI_SLV_ERR_CNT_EN adds err_cnt/err_clr.
// Latency: rx_valid <= SYNC_STG+2 clk after the last sampling pin edge.
// Backpressure: one-word tx buffer (tx_ready = empty); an empty buffer at word start sends all-ones and pulses tx_udr.
module spi_slv
    import spi_pkg::*;
#(
    parameter int DW       = 32,
    parameter int SYNC_STG = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          spi_csn,
    input  logic          spi_clk,
    input  logic          spi_mosi,
    output logic          spi_miso,
    output logic          spi_miso_oe,
    input  logic          r_spi_cpol,
    input  logic          r_spi_cpha,
    input  logic [1:0]    r_wd_len,
    input  logic [DW-1:0] tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic [DW-1:0] rx_data,
    output logic          rx_valid,
    output logic          tx_udr,
    output logic          busy
`ifdef SPI_SLV_ERR_CNT_EN
    ,
    input  logic          err_clr,
    output logic [15:0]   err_cnt
`endif
);

    t_spi_slv_st   state_q, state_d;
    t_spi_slv_cfg  cfg_q, cfg_d;
    logic [4:0]    cnt_q, cnt_d;
    logic          hold_q, hold_d;
    logic          part_q, part_d;
    logic [DW-1:0] tx_sh_q, tx_sh_d;
    logic [DW-1:0] rx_sh_q, rx_sh_d;
    logic [DW-1:0] rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          tx_udr_q, tx_udr_d;
    logic [DW-1:0] tx_buf_q, tx_buf_d;
    logic          tx_full_q, tx_full_d;

    logic csn_s, mosi_s, lead_p, trail_p, csn_fall_p, csn_rise_p;
    logic samp_p, shft_p, do_load, wr, abort;
    logic [5:0] ld_bits, sh_amt;

    spi_slv_sync #(.SYNC_STG(SYNC_STG)) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_csn   (spi_csn),
        .spi_clk   (spi_clk),
        .spi_mosi  (spi_mosi),
        .cpol      (cfg_q.cpol),
        .csn_s     (csn_s),
        .mosi_s    (mosi_s),
        .lead_p    (lead_p),
        .trail_p   (trail_p),
        .csn_fall_p(csn_fall_p),
        .csn_rise_p(csn_rise_p)
    );

    assign samp_p  = cfg_q.cpha ? trail_p : lead_p;
    assign shft_p  = cfg_q.cpha ? lead_p : trail_p;
    assign wr      = tx_valid && !tx_full_q;
    assign ld_bits = (state_q == IDLE) ? spi_wd_bits(r_wd_len) : spi_wd_bits(cfg_q.wd_len);
    assign sh_amt  = 6'(DW) - ld_bits;

    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        part_d     = part_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_udr_d   = 1'b0;
        do_load    = 1'b0;
        abort      = 1'b0;

        case (state_q)
            IDLE: begin
                if (csn_fall_p) begin
                    state_d = ACTIVE;
                    cfg_d   = '{cpol: r_spi_cpol, cpha: r_spi_cpha, wd_len: r_wd_len};
                    cnt_d   = 5'(ld_bits - 6'd1);
                    hold_d  = r_spi_cpha;
                    part_d  = 1'b0;
                    rx_sh_d = '0;
                    do_load = 1'b1;
                end
            end
            default: begin
                if (csn_rise_p || csn_s) begin
                    state_d = IDLE;
                    abort   = part_q;
                end else begin
                    if (samp_p) begin
                        rx_sh_d = {rx_sh_q[DW-2:0], mosi_s};
                        part_d  = 1'b1;
                        if (cnt_q == 5'd0) begin
                            rx_data_d  = rx_sh_d;
                            rx_valid_d = 1'b1;
                            rx_sh_d    = '0;
                            part_d     = 1'b0;
                        end
                    end
                    // CPHA=1 first shift edge: bit len-1 is already on MISO.
                    if (shft_p) begin
                        if (hold_q) begin
                            hold_d = 1'b0;
                        end else if (cnt_q == 5'd0) begin
                            do_load = 1'b1;
                            cnt_d   = 5'(ld_bits - 6'd1);
                        end else begin
                            tx_sh_d = tx_sh_q << 1;
                            cnt_d   = cnt_q - 5'd1;
                        end
                    end
                end
            end
        endcase

        // Word load sees the buffer as it was before any write this cycle.
        if (do_load) begin
            if (tx_full_q) begin
                tx_sh_d = tx_buf_q << sh_amt;
            end else begin
                tx_sh_d  = '1;
                tx_udr_d = 1'b1;
            end
        end

        tx_buf_d  = wr ? tx_data : tx_buf_q;
        tx_full_d = wr ? 1'b1 : (do_load ? 1'b0 : tx_full_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cfg_q      <= '0;
            cnt_q      <= '0;
            hold_q     <= 1'b0;
            part_q     <= 1'b0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_udr_q   <= 1'b0;
            tx_buf_q   <= '0;
            tx_full_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            part_q     <= part_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_udr_q   <= tx_udr_d;
            tx_buf_q   <= tx_buf_d;
            tx_full_q  <= tx_full_d;
        end
    end

    assign busy        = (state_q == ACTIVE);
    assign spi_miso_oe = (state_q == ACTIVE);
    assign spi_miso    = tx_sh_q[DW-1];
    assign tx_ready    = !tx_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_udr      = tx_udr_q;

`ifdef SPI_SLV_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [16:0] err_sum;

    always_comb begin
        err_sum   = {1'b0, err_cnt_q} + {15'd0, tx_udr_d} + {15'd0, abort};
        err_cnt_d = err_clr ? 16'd0 : (err_sum[16] ? 16'hFFFF : err_sum[15:0]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= 16'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule
